devolver_cedulas_seq: RTL

Parametrised successor to the single-shot cash-return LED driver. It returns stored banknotes one at a time across CHANNELS denominations. Each ejected note produces a timed actuator/LED pulse, followed by a mandatory gap. The block sits between the vending-machine control FSM, which issues the return request and supplies the per-denomination note counts, and the note-eject LEDs/actuators.

---
 rtl/devolver_cedulas_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/devolver_cedulas_seq.sv
// Sequential banknote return: ejects stored notes one at a time, channel 0 first,
// each as a timed eject pulse followed by a mandatory idle gap.
module devolver_cedulas_seq #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    devolver_dinheiro,
  input  logic                                    cancelar,
  input  logic [CHANNELS*CNT_W-1:0]               contagem,
  output logic [CHANNELS-1:0]                     led,
  output logic                                    ocupado,
  output logic                                    concluido,
  output logic [CNT_W+$clog2(CHANNELS+1)-1:0]     restante
);

  localparam int SUM_W   = CNT_W + $clog2(CHANNELS + 1);
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t                           state, state_nxt;
  logic [CHANNELS-1:0][CNT_W-1:0]   cnt, cnt_nxt;
  logic [TMR_W-1:0]                 timer, timer_nxt;
  logic [SEL_W-1:0]                 sel, sel_nxt, pick;
  logic [CHANNELS-1:0]              led_nxt;
  logic                             req_prev, accept, any_nz;

  function automatic logic [SUM_W-1:0] sum_counts(input logic [CHANNELS-1:0][CNT_W-1:0] c);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < CHANNELS; i++) s = s + SUM_W'(c[i]);
    return s;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    timer_nxt = timer;
    sel_nxt   = sel;
    accept    = devolver_dinheiro && !req_prev && (state == S_IDLE);
    any_nz    = 1'b0;
    pick      = '0;
    // Descending scan so the lowest-index nonzero channel wins.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (cnt[i] != '0) begin
        any_nz = 1'b1;
        pick   = SEL_W'(i);
      end
    end

    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt   = contagem;
          state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        if (cancelar || !any_nz) begin
          state_nxt = S_DONE;
        end else begin
          sel_nxt   = pick;
          timer_nxt = TMR_W'(PULSE_CYCLES);
          state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        if (timer == TMR_W'(1)) begin
          if (cnt[sel] != '0) cnt_nxt[sel] = cnt[sel] - CNT_W'(1);
          timer_nxt = TMR_W'(GAP_CYCLES);
          state_nxt = cancelar ? S_DONE : S_GAP;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (cancelar) begin
          timer_nxt = '0;
          state_nxt = S_DONE;
        end else if (timer == TMR_W'(1)) begin
          timer_nxt = '0;
          state_nxt = S_SELECT;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    led_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      led_nxt[i] = (state_nxt == S_PULSE) && (sel_nxt == SEL_W'(i));
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      timer     <= '0;
      sel       <= '0;
      req_prev  <= 1'b1;
      led       <= '0;
      ocupado   <= 1'b0;
      concluido <= 1'b0;
      restante  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      timer     <= timer_nxt;
      sel       <= sel_nxt;
      req_prev  <= devolver_dinheiro;
      led       <= led_nxt;
      ocupado   <= (state_nxt != S_IDLE);
      concluido <= (state_nxt == S_DONE);
      restante  <= sum_counts(cnt_nxt);
    end
  end

endmodule
